// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared handshake/state encodings for the USB endpoint arbiter
package usb_pkg;

  localparam int EP_W  = 3;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NONE  = 2'b01,
    HS_NAK   = 2'b10,
    HS_STALL = 2'b11
  } hs_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IN_DATA  = 2'b01,
    ST_OUT_DATA = 2'b10,
    ST_DRAIN    = 2'b11
  } state_e;

endpackage

// File: rtl/usb_toggle_bank.sv
// rtl/usb_toggle_bank.sv - per-endpoint DATA0/DATA1 toggle bits with set/clear/invert
module usb_toggle_bank
  import usb_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EP_W-1:0]   sel,
  input  logic              set,
  input  logic              clr,
  input  logic              inv,
  output logic [NUM_EP-1:0] toggles
);

  logic [NUM_EP-1:0] tog_q, tog_d;

  // clear wins over set, set wins over invert
  always_comb begin
    tog_d = tog_q;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel == EP_W'(i)) begin
        if (clr)      tog_d[i] = 1'b0;
        else if (set) tog_d[i] = 1'b1;
        else if (inv) tog_d[i] = ~tog_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tog_q <= '0;
    else     tog_q <= tog_d;
  end

  assign toggles = tog_q;

endmodule

// File: rtl/usb_ep_arbiter.sv
// rtl/usb_ep_arbiter.sv - routes USB token/data phases to per-endpoint IN/OUT FIFOs
module usb_ep_arbiter
  import usb_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 64
) (
  input  logic                clk_48,
  input  logic                rst,
  input  logic                transaction_active,
  input  logic [3:0]          endpoint,
  input  logic                direction_in,
  input  logic                setup,
  input  logic                data_strobe,
  input  logic                success,
  input  logic [7:0]          data_out,
  output logic [7:0]          data_in,
  output logic                data_in_valid,
  output logic [1:0]          handshake,
  output logic                data_toggle,
  input  logic [NUM_EP-1:0]   ep_enable,
  input  logic [NUM_EP-1:0]   ep_stall,
  input  logic [8*NUM_EP-1:0] in_data,
  input  logic [NUM_EP-1:0]   in_empty,
  output logic [NUM_EP-1:0]   in_rd,
  output logic [7:0]          out_data,
  output logic [NUM_EP-1:0]   out_wr,
  input  logic [NUM_EP-1:0]   out_full,
  output logic [NUM_EP-1:0]   out_commit,
  output logic [NUM_EP-1:0]   out_abort
);

  state_e              state_q, state_d;
  hs_e                 hs_q, hs_d;
  logic                ta_q, ta_d;
  logic [EP_W-1:0]     ep_q, ep_d;
  logic                setup_q, setup_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [NUM_EP-1:0]   out_wr_q, out_wr_d;
  logic [NUM_EP-1:0]   commit_q, commit_d;
  logic [NUM_EP-1:0]   abort_q, abort_d;

  logic [EP_W-1:0]     tog_sel;
  logic                tog_set, tog_clr, tog_inv;
  logic [NUM_EP-1:0]   toggles;

  logic [EP_W-1:0]     ep_idx;
  logic [NUM_EP-1:0]   start_oh, ep_oh_q;
  logic                in_range;
  logic [7:0]          in_sel;

  assign ep_idx   = endpoint[EP_W-1:0];
  assign in_range = endpoint < 4'(NUM_EP);
  assign start_oh = NUM_EP'(1) << ep_idx;
  assign ep_oh_q  = NUM_EP'(1) << ep_q;

  always_comb begin
    in_sel = 8'h00;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_q == EP_W'(i)) in_sel = in_data[i*8 +: 8];
    end
  end

  assign data_in_valid = (state_q == ST_IN_DATA) && (cnt_q < CNT_W'(MAX_PKT))
                         && !(|(in_empty & ep_oh_q));
  assign data_in       = (state_q == ST_IN_DATA) ? in_sel : 8'h00;
  assign handshake     = hs_q;
  assign data_toggle   = |(toggles & ep_oh_q);
  assign out_data      = out_data_q;
  assign out_wr        = out_wr_q;
  assign out_commit    = commit_q;
  assign out_abort     = abort_q;

  always_comb begin
    state_d    = state_q;
    hs_d       = hs_q;
    ta_d       = transaction_active;
    ep_d       = ep_q;
    setup_d    = setup_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_wr_d   = '0;
    commit_d   = '0;
    abort_d    = '0;
    in_rd      = '0;
    tog_sel    = ep_q;
    tog_set    = 1'b0;
    tog_clr    = 1'b0;
    tog_inv    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (transaction_active && !ta_q) begin
          ep_d    = ep_idx;
          setup_d = setup;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          tog_sel = ep_idx;
          if (!in_range || !(|(ep_enable & start_oh))) begin
            hs_d    = HS_STALL;
            state_d = ST_DRAIN;
          end else if (|(ep_stall & start_oh) && !setup) begin
            hs_d    = HS_STALL;
            state_d = ST_DRAIN;
          end else if (direction_in && !setup) begin
            hs_d    = (|(in_empty & start_oh)) ? HS_NAK : HS_ACK;
            state_d = (|(in_empty & start_oh)) ? ST_DRAIN : ST_IN_DATA;
          end else begin
            // a SETUP always restarts the control pipe on DATA0
            tog_clr = setup;
            hs_d    = (|(out_full & start_oh)) ? HS_NAK : HS_ACK;
            state_d = (|(out_full & start_oh)) ? ST_DRAIN : ST_OUT_DATA;
          end
        end
      end

      ST_IN_DATA: begin
        if (data_strobe && data_in_valid) begin
          in_rd = ep_oh_q;
          cnt_d = cnt_q + 1'b1;
        end
        if (success) begin
          tog_inv = 1'b1;
          state_d = transaction_active ? ST_DRAIN : ST_IDLE;
        end else if (!transaction_active) begin
          state_d = ST_IDLE;
        end
      end

      ST_OUT_DATA: begin
        if (data_strobe) begin
          if (ovf_q || |(out_full & ep_oh_q)) begin
            ovf_d = 1'b1;
          end else begin
            out_wr_d   = ep_oh_q;
            out_data_d = data_out;
          end
        end
        // an overflowed packet is discarded even if the host saw a good CRC
        if (success || !transaction_active) begin
          if (success && !ovf_d) begin
            commit_d = ep_oh_q;
            tog_set  = setup_q;
            tog_inv  = !setup_q;
          end else begin
            abort_d = ep_oh_q;
          end
          state_d = transaction_active ? ST_DRAIN : ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (!transaction_active) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ta_q resets high so a transaction still active across reset is never restarted
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hs_q       <= HS_ACK;
      ta_q       <= 1'b1;
      ep_q       <= '0;
      setup_q    <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= 8'h00;
      out_wr_q   <= '0;
      commit_q   <= '0;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hs_d;
      ta_q       <= ta_d;
      ep_q       <= ep_d;
      setup_q    <= setup_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      commit_q   <= commit_d;
      abort_q    <= abort_d;
    end
  end

  usb_toggle_bank #(
    .NUM_EP (NUM_EP)
  ) u_toggle_bank (
    .clk     (clk_48),
    .rst     (rst),
    .sel     (tog_sel),
    .set     (tog_set),
    .clr     (tog_clr),
    .inv     (tog_inv),
    .toggles (toggles)
  );

endmodule

// File: doc/usb_ep_arbiter.md
USB_EP_ARBITER -- requirements
Module: usb_ep_arbiter

Interface
REQ-001 Parameter NUM_EP, 4: number of endpoints served (EP0..NUM_EP-1), 1..8.
REQ-002 Parameter MAX_PKT, 64: maximum bytes per IN packet.
REQ-003 clk_48  in  1  48 MHz system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 transaction_active  in  1  high for the duration of a token/data/handshake transaction.
REQ-006 endpoint  in  4  endpoint number of the current token.
REQ-007 direction_in  in  1  1 = IN token (device to host).
REQ-008 setup  in  1  1 = SETUP token.
REQ-009 data_strobe  in  1  one-cycle byte strobe: byte consumed (IN) or data_out valid (OUT).
REQ-010 success  in  1  one-cycle pulse: data CRC good (OUT) or host ACK received (IN).
REQ-011 data_out  in  8  received OUT/SETUP byte.
REQ-012 data_in  out  8  byte presented to the core for IN.
REQ-013 data_in_valid  out  1  more IN bytes remain in the current packet.
REQ-014 handshake  out  2  00 ACK, 01 NONE, 10 NAK, 11 STALL.
REQ-015 data_toggle  out  1  DATA0/DATA1 for the current endpoint.
REQ-016 ep_enable  in  NUM_EP  endpoint configured; ep_stall  in  NUM_EP  endpoint halted.
REQ-017 in_data  in  8*NUM_EP  first-word-fall-through head of each IN FIFO; in_empty  in  NUM_EP; in_rd  out  NUM_EP  one-cycle pop.
REQ-018 out_data  out  8  shared OUT byte; out_wr  out  NUM_EP  write strobe; out_full  in  NUM_EP; out_commit  out  NUM_EP  one-cycle pulse on good packet; out_abort  out  NUM_EP  one-cycle pulse on bad/aborted packet.

Function
REQ-019 States: IDLE, IN_DATA, OUT_DATA, DRAIN; IDLE is entered on reset.
REQ-020 Transaction start = rising edge of transaction_active; all decisions latch endpoint/direction_in/setup on that edge, and handshake/data_toggle are registered and valid one cycle later.
REQ-021 endpoint >= NUM_EP or ep_enable bit low -> handshake STALL, state DRAIN.
REQ-022 ep_stall set and not setup -> handshake STALL, DRAIN; SETUP on EP0 is always ACKed regardless of ep_stall.
REQ-023 IN with in_empty set -> handshake NAK, data_in_valid 0, DRAIN.
REQ-024 IN with data -> handshake ACK, state IN_DATA; data_in = selected in_data; data_in_valid = 1 while byte count < MAX_PKT and FIFO not empty.
REQ-025 Each data_strobe in IN_DATA pulses in_rd for the selected endpoint exactly once and increments the 7-bit byte count; count saturates at MAX_PKT.
REQ-026 OUT/SETUP with out_full set at start -> handshake NAK, no out_wr, DRAIN.
REQ-027 OUT/SETUP otherwise -> handshake ACK, state OUT_DATA; each data_strobe produces out_wr on the selected endpoint with out_data = data_out in the same registered cycle.
REQ-028 out_full rising mid-packet -> further bytes dropped, out_abort pulsed at transaction end, toggle unchanged.
REQ-029 success in OUT_DATA -> out_commit pulse, toggle inverted; transaction_active falling without success -> out_abort pulse, toggle unchanged.
REQ-030 success in IN_DATA -> toggle inverted; transaction end without success -> toggle unchanged (host retries; FIFO bytes already popped are the caller's concern).
REQ-031 SETUP token forces EP0 toggle to 0 before the data phase and to 1 after success.
REQ-032 Per-endpoint toggle bits held in a NUM_EP register; data_toggle reflects the latched endpoint.
REQ-033 Any state returns to IDLE on transaction_active low; success and fall in the same cycle are treated as success.
REQ-034 in_rd, out_wr, out_commit, out_abort are mutually exclusive across endpoints (one-hot or zero).

Reset
REQ-035 On rst: state IDLE, all toggles 0, data_in 0, data_in_valid 0, handshake ACK, data_toggle 0, in_rd/out_wr/out_commit/out_abort 0, byte count 0.
REQ-036 rst mid-transaction aborts silently: no out_commit/out_abort pulse is emitted.

Structure
REQ-037 Handshake encodings (ACK/NONE/NAK/STALL) and state encodings belong in shared package usb_pkg.
REQ-038 One sub-module, usb_toggle_bank, holds per-endpoint toggle bits with set/clear/invert ports.

Verification
REQ-039 IN EP1, FIFO holds 3 bytes 0xA1,0xA2,0xA3, 3 strobes + success -> data_in sequence A1,A2,A3, in_rd[1] x3, toggle1 0->1.
REQ-040 IN EP2 with in_empty[2]=1 -> handshake 10, zero in_rd pulses, toggle unchanged.
REQ-041 OUT EP1, 4 bytes, success -> out_wr[1] x4, out_commit[1] once, toggle1 inverted; repeat without success -> out_abort[1], toggle held.
REQ-042 SETUP EP0 with ep_stall[0]=1, 8 bytes -> handshake 00, 8 out_wr[0], toggle0 = 1 after success.
REQ-043 Token to endpoint 5 (NUM_EP=4) or disabled EP3 -> handshake 11, no strobes on any port.
REQ-044 rst asserted after 2 OUT bytes -> all outputs reset next cycle, no commit/abort pulse.
